// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output chain: counter/duty widths,
// the default period length and the gate-driver state encoding.
package pwm_pkg;

    localparam int PWM_PERIOD_MAX = 333;
    localparam int CNT_W          = 9;
    localparam int DUTY_W         = 9;
    localparam int DT_W           = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_L_ON  = 3'd1,
        ST_DT_LH = 3'd2,
        ST_H_ON  = 3'd3,
        ST_DT_HL = 3'd4
    } pwm_state_t;

endpackage

// File: rtl/deadtime_timer.sv
// Dead-time down-counter shared by both dead-time states: loads DT-1 on
// entry, counts down while a dead-time state is held, flags zero.
module deadtime_timer
    import pwm_pkg::*;
#(
    parameter int DT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    logic [DT_W-1:0] r_cnt;

    // Count register: load has priority, decrement stops at zero.
    // NOTE: synchronous active-high reset inside the clocked block, and
    // non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= DT_W'(DT - 1);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pwm_deadtime_out.sv
// PWM output stage: shadowed and clamped duty register, duty demand
// compare against the period counter, and a complementary gate FSM that
// inserts dead time on every high/low side change.
module pwm_deadtime_out
    import pwm_pkg::*;
#(
    parameter int PERIOD_MAX = PWM_PERIOD_MAX,
    parameter int DT         = 8,
    parameter int DUTY_MIN   = 16,
    parameter int DUTY_MAX   = 317
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CNT_W-1:0]  cnt_pwm,
    input  logic              e,
    input  logic [DUTY_W-1:0] te,
    output logic              pwm_h,
    output logic              pwm_l,
    output logic [DUTY_W-1:0] duty_applied,
    output logic              sat,
    output logic              dt_active
);

    // A duty beyond the last counter value can never be reached, so the
    // upper clamp never exceeds the period end.
    localparam int LP_DUTY_HI = (DUTY_MAX < PERIOD_MAX) ? DUTY_MAX : PERIOD_MAX;

    logic [DUTY_W-1:0] r_duty_sh;
    logic              r_sat;
    pwm_state_t        r_state;
    pwm_state_t        w_state_nxt;
    logic [DUTY_W-1:0] w_te_clamped;
    logic [DUTY_W-1:0] w_d_eff;
    logic              w_dem;
    logic              w_dt_load;
    logic              w_dt_dec;
    logic              w_dt_zero;

    // Clamp the requested duty: drop tiny pulses, limit long ones.
    always_comb begin
        if (te < DUTY_W'(DUTY_MIN)) begin
            w_te_clamped = '0;
        end else if (te > DUTY_W'(LP_DUTY_HI)) begin
            w_te_clamped = DUTY_W'(LP_DUTY_HI);
        end else begin
            w_te_clamped = te;
        end
    end

    // The fresh duty is used directly in cycle 0 so it governs its whole period.
    assign w_d_eff = e ? w_te_clamped : r_duty_sh;
    assign w_dem   = (cnt_pwm < w_d_eff);

    // Shadow duty and saturation flag, captured only at the period strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_sh <= '0;
            r_sat     <= 1'b0;
        end else if (e) begin
            r_duty_sh <= w_te_clamped;
            r_sat     <= (w_te_clamped != te);
        end
    end

    // Gate FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Gate FSM next state; a disabled stage always falls back to IDLE.
    // NOTE: next state defaults to the current state before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (e) w_state_nxt = w_dem ? ST_DT_LH : ST_L_ON;
                end
                ST_L_ON: begin
                    if (w_dem) w_state_nxt = ST_DT_LH;
                end
                ST_DT_LH: begin
                    if (!w_dem)         w_state_nxt = ST_L_ON;
                    else if (w_dt_zero) w_state_nxt = ST_H_ON;
                end
                ST_H_ON: begin
                    if (!w_dem) w_state_nxt = ST_DT_HL;
                end
                ST_DT_HL: begin
                    if (w_dem)          w_state_nxt = ST_H_ON;
                    else if (w_dt_zero) w_state_nxt = ST_L_ON;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Reload the timer on every fresh entry into a dead-time state.
    assign w_dt_load = ((w_state_nxt == ST_DT_LH) || (w_state_nxt == ST_DT_HL)) &&
                       (w_state_nxt != r_state);
    assign w_dt_dec  = (r_state == ST_DT_LH) || (r_state == ST_DT_HL);

    deadtime_timer #(
        .DT (DT)
    ) u_deadtime_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_dt_load),
        .i_dec  (w_dt_dec),
        .o_zero (w_dt_zero)
    );

    // Gate outputs decode the registered state only, so they cannot glitch.
    assign pwm_h        = (r_state == ST_H_ON);
    assign pwm_l        = (r_state == ST_L_ON);
    assign dt_active    = w_dt_dec;
    assign duty_applied = r_duty_sh;
    assign sat          = r_sat;

endmodule

// File: doc/pwm_deadtime_out.md
# pwm_deadtime_out

Output stage of the open-loop PWM chain, directly downstream of the PWM period/register block. It consumes the free-running period counter `cnt_pwm`, the period-end strobe `e` and the duty word `te`. It produces complementary high-side and low-side gate signals with dead-time insertion, duty clamping and a shadowed duty register that updates only at period boundaries. Both gates are never high in the same cycle.

## Interface
Parameters:
- `PERIOD_MAX`, 333: last value of `cnt_pwm`; the period is 334 clk cycles.
- `DT`, 8: dead time in clk cycles, range 1..15.
- `DUTY_MIN`, 16: requested duty below this maps to 0 (pulse dropped).
- `DUTY_MAX`, 317: requested duty above this clamps to `DUTY_MAX`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  output enable; low forces both gates off.
- `cnt_pwm`  in  9  period counter 0..`PERIOD_MAX`, +1 per clk.
- `e`  in  1  one-cycle strobe, high exactly when `cnt_pwm`==0.
- `te`  in  9  requested duty in counts.
- `pwm_h`  out  1  high-side gate.
- `pwm_l`  out  1  low-side gate.
- `duty_applied`  out  9  clamped duty in force for the current period.
- `sat`  out  1  high for the period if `te` was clamped or dropped at the last `e`.
- `dt_active`  out  1  FSM is in a dead-time state.

## Operation
- Clamp function: `clamp(x)` = 0 if x<`DUTY_MIN`; `DUTY_MAX` if x>`DUTY_MAX`; otherwise x.
- Shadow register: on `e`, `duty_sh <= clamp(te)` and `sat <= (clamp(te)!=te)`. `te` is ignored at all other times.
- Effective duty: `d_eff = e ? clamp(te) : duty_sh`, so the new duty takes effect in cycle 0 of its period.
- Demand: `dem = (cnt_pwm < d_eff)`, unsigned 9-bit compare.
- FSM states and gate outputs:
  - IDLE: h=0, l=0.
  - L_ON: l=1.
  - DT_LH: both 0.
  - H_ON: h=1.
  - DT_HL: both 0.
- Outputs are decoded from the registered state only.
- 4-bit dead-time counter `dt_cnt` is loaded with DT-1 on entry to either DT state and decrements each cycle.
- FSM transitions:
  - IDLE: if `en` and `e`: go to DT_LH when dem=1, else L_ON. Otherwise stay in IDLE.
  - L_ON: dem=1 -> DT_LH.
  - DT_LH: dem=0 -> L_ON immediately (abort). Otherwise, when dt_cnt==0 -> H_ON.
  - H_ON: dem=0 -> DT_HL.
  - DT_HL: dem=1 -> H_ON immediately (abort). Otherwise, when dt_cnt==0 -> L_ON.
- `en`=0 in any state -> IDLE at the next edge. Both gates are low from the cycle after.
- `en` re-asserted mid-period: stay in IDLE until the next `e`.
- `duty_applied` = `duty_sh`.

## Timing
- Reset values: `pwm_h`=0, `pwm_l`=0, `duty_applied`=0, `sat`=0, `dt_active`=0; state IDLE, `dt_cnt`=0.
- Latency: a dem edge at clk k changes the state at k+1. Each DT state is held exactly DT cycles unless aborted.
- Duty d (DUTY_MIN≤d≤DUTY_MAX), steady state:
  - `pwm_h` high for `cnt_pwm` = DT+1 .. d (d−DT cycles).
  - `pwm_l` high for `cnt_pwm` = d+DT+1 .. PERIOD_MAX, and at 0 (PERIOD_MAX−d−DT+1 cycles).
- Duty 0: dem is never 1, so the FSM stays in L_ON and `pwm_l` is constantly high.
- Duty change: takes effect at the `e` cycle. No partial or glitch pulse results from a mid-period `te` change.
- `rst` has priority over `en` and `e`. `rst` mid-period drops both gates at the next edge.

## Structure
- Shared package `pwm_pkg`: PERIOD_MAX, counter width (9), duty width (9), FSM state enum, DT width (4).
- One natural sub-module, `deadtime_timer`: load/decrement/zero-flag counter used by both DT states.
- The clamp logic and shadow register stay inline.

## Test plan
- Reset with `en`=1, `te`=167 -> gates 0 until first `e`. Then `pwm_h` high at cnt 9..167 (159 cycles), `pwm_l` high at cnt 176..333 and 0 (159 cycles). Dead gaps are cnt 1..8 and 168..175.
- `te`=5 -> `duty_applied`=0, `sat`=1, `pwm_l` constantly high. `te`=330 -> `duty_applied`=317, `sat`=1, `pwm_h` high at cnt 9..317.
- `te` changes 100->200 at cnt 150 -> current period keeps falling edge at cnt 100. Next period falls at cnt 200.
- `en` dropped at cnt 50 with duty 167 -> both gates 0 from cnt 51. After re-enable at cnt 200, both stay 0 until the next `e`, then resume normal pattern.
- Force dem low 3 cycles into DT_LH (`duty_sh`=3 via direct shadow poke, bypassing clamp) -> abort to L_ON, `pwm_h` never asserts, `pwm_l` resumes after DT_LH.
- Whole run: assert `!(pwm_h && pwm_l)` every cycle. Any h↔l transition must be separated by ≥DT cycles with both gates low.
